// File: rtl/palette_pkg.sv
// Shared types and reset contents for palette_mapper: the RGB struct,
// the standard game colours, the default grey, and the reset-palette lookup.
package palette_pkg;

  localparam int PAL_CH_W = 8;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t COLOR_WHITE   = 24'hffffff;
  localparam rgb_t COLOR_BLACK   = 24'h000000;
  localparam rgb_t COLOR_GREEN   = 24'h27b212;
  localparam rgb_t COLOR_RED     = 24'hd80222;
  localparam rgb_t COLOR_SKY     = 24'h5db1f0;
  localparam rgb_t COLOR_YELLOW  = 24'hf1ff0a;
  localparam rgb_t COLOR_GREY    = 24'hb2b2b0;
  localparam rgb_t COLOR_ORANGE  = 24'hf27a00;
  localparam rgb_t COLOR_BROWN   = 24'h663300;
  localparam rgb_t COLOR_PURPLE  = 24'h8600b3;
  localparam rgb_t COLOR_NAVY    = 24'h000066;
  localparam rgb_t COLOR_DEFAULT = 24'hb2b2b0;

  // Reset value of palette entry idx; entries past the standard set are grey.
  function automatic rgb_t reset_color(input int idx);
    case (idx)
      0:       return COLOR_WHITE;
      1:       return COLOR_BLACK;
      2:       return COLOR_GREEN;
      3:       return COLOR_RED;
      4:       return COLOR_SKY;
      5:       return COLOR_YELLOW;
      6:       return COLOR_GREY;
      7:       return COLOR_ORANGE;
      8:       return COLOR_BROWN;
      9:       return COLOR_PURPLE;
      10:      return COLOR_NAVY;
      default: return COLOR_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/palette_mapper_blink_timer.sv
// blink_timer: counts frame_start pulses and toggles the blink phase every
// BLINK_FRAMES frames. phase is the value in force for the coming clock edge,
// so a toggle applies to pixels entering stage 2 on the wrapping edge itself.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_start,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next frame count and phase; wrap and toggle on the last frame of a half-period.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and phase state; phase starts "on".
  always_ff @(posedge Clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (Reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule

// File: rtl/palette_mapper.sv
// palette_mapper: two-stage registered colour-code to VGA RGB mapper with a
// writable, reset-loaded palette, blanking override and per-entry blink.
// Optional macro PALETTE_FADE_EN adds a fade_level input that scales each
// channel by (fade_level+1)/16 in stage 2. CH_W is expected to match the
// 8-bit channels of the package colour constants.
module palette_mapper
  import palette_pkg::*;
#(
  parameter int CODE_W       = 6,
  parameter int NUM_COLORS   = 16,
  parameter int CH_W         = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_valid,
  input  logic [CODE_W-1:0] colorcode,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_addr,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              wr_blink,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]        fade_level,
`endif
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B,
  output logic              out_valid,
  output logic              wr_err
);

  localparam int IDX_W = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;

  // Palette register file and write-error flag
  logic [3*CH_W-1:0] pal_q [NUM_COLORS];
  logic [3*CH_W-1:0] pal_d [NUM_COLORS];
  logic [NUM_COLORS-1:0] blink_q, blink_d;
  logic wr_err_q, wr_err_d;
  logic wr_in_range;

  // Stage 1 (captured pixel) and stage 2 (output) registers
  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic              s1_blank_q, s1_blank_d;
  logic              s2_valid_q, s2_valid_d;
  logic [3*CH_W-1:0] s2_rgb_q, s2_rgb_d;
`ifdef PALETTE_FADE_EN
  logic [3:0]        s1_fade_q, s1_fade_d;
`endif

  logic phase;

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink_timer (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .phase       (phase)
  );

`ifdef PALETTE_FADE_EN
  // Scales one channel by (lvl+1)/16; lvl = 15 is the identity.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c, input logic [3:0] lvl);
    logic [CH_W+4:0] prod;
    prod = {5'd0, c} * {{CH_W{1'b0}}, {1'b0, lvl} + 5'd1};
    return prod[CH_W+3:4];
  endfunction
`endif

  // Palette writes: in-range writes update colour and blink, out-of-range ones raise wr_err.
  always_comb begin
    wr_in_range = (int'(wr_addr) < NUM_COLORS);
    pal_d       = pal_q;
    blink_d     = blink_q;
    wr_err_d    = wr_err_q;
    if (wr_en) begin
      if (wr_in_range) begin
        pal_d[wr_addr[IDX_W-1:0]]   = wr_rgb;
        blink_d[wr_addr[IDX_W-1:0]] = wr_blink;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // Palette state; reset reloads the standard colours and drops user writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: this register file is deliberately reset because its contents are part of the reset state.
      for (int i = 0; i < NUM_COLORS; i++) begin
        pal_q[i] <= (3*CH_W)'(reset_color(i));
      end
      blink_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      pal_q    <= pal_d;
      blink_q  <= blink_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Stage 1 captures the pixel unconditionally; stage 2 resolves its colour.
  always_comb begin
    s1_valid_d = pix_valid;
    s1_code_d  = colorcode;
    s1_blank_d = blank;
`ifdef PALETTE_FADE_EN
    s1_fade_d  = fade_level;
`endif
    s2_valid_d = s1_valid_q;
    s2_rgb_d   = (3*CH_W)'(COLOR_DEFAULT);
    if (s1_blank_q) begin
      s2_rgb_d = '0;
    end else if (int'(s1_code_q) < NUM_COLORS) begin
      if (blink_q[s1_code_q[IDX_W-1:0]] && !phase) begin
        s2_rgb_d = '0;
      end else begin
        s2_rgb_d = pal_q[s1_code_q[IDX_W-1:0]];
      end
    end
`ifdef PALETTE_FADE_EN
    s2_rgb_d = {fade_ch(s2_rgb_d[3*CH_W-1 -: CH_W], s1_fade_q),
                fade_ch(s2_rgb_d[2*CH_W-1 -: CH_W], s1_fade_q),
                fade_ch(s2_rgb_d[CH_W-1:0],         s1_fade_q)};
`endif
  end

  // Pipeline registers; reset flushes both stages.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_blank_q <= 1'b0;
`ifdef PALETTE_FADE_EN
      s1_fade_q  <= '0;
`endif
      s2_valid_q <= 1'b0;
      s2_rgb_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_blank_q <= s1_blank_d;
`ifdef PALETTE_FADE_EN
      s1_fade_q  <= s1_fade_d;
`endif
      s2_valid_q <= s2_valid_d;
      s2_rgb_q   <= s2_rgb_d;
    end
  end

  assign VGA_R     = s2_rgb_q[3*CH_W-1 -: CH_W];
  assign VGA_G     = s2_rgb_q[2*CH_W-1 -: CH_W];
  assign VGA_B     = s2_rgb_q[CH_W-1:0];
  assign out_valid = s2_valid_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_palette_mapper.sv
// Directed testbench for palette_mapper (BLINK_FRAMES = 2). Each pixel is
// given with its hand-computed colour; it is compared when it reaches the
// outputs one call later (two edges after it was presented).
module tb_palette_mapper;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [5:0]  colorcode = '0;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [23:0] wr_rgb = '0;
  logic        wr_blink = 1'b0;
`ifdef PALETTE_FADE_EN
  logic [3:0]  fade_level = 4'd15;
`endif
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        out_valid;
  logic        wr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic        pend_v = 1'b0;
  logic [23:0] pend_rgb = '0;
  string       pend_tag = "reset";

  palette_mapper #(
    .CODE_W(6), .NUM_COLORS(16), .CH_W(8), .BLINK_FRAMES(2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_valid   (pix_valid),
    .colorcode   (colorcode),
    .blank       (blank),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_rgb      (wr_rgb),
    .wr_blink    (wr_blink),
`ifdef PALETTE_FADE_EN
    .fade_level  (fade_level),
`endif
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .out_valid   (out_valid),
    .wr_err      (wr_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one pixel for one edge, then compare the previous pixel's output.
  task automatic px(input string tag, input logic v, input logic [5:0] code,
                    input logic b, input logic [23:0] exp);
    pix_valid = v;
    colorcode = code;
    blank     = b;
    @(posedge Clk);
    #1;
    wr_en       = 1'b0;
    frame_start = 1'b0;
    check({pend_tag, " valid"}, 32'(out_valid), 32'(pend_v));
    if (pend_v) check({pend_tag, " rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, pend_rgb});
    pend_v   = v;
    pend_rgb = exp;
    pend_tag = tag;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset wr_err", 32'(wr_err), 32'd0);
    Reset = 1'b0;

    // Default palette, out-of-range codes and blanking
    px("code0",  1'b1, 6'd0,  1'b0, 24'hffffff);
    px("code2",  1'b1, 6'd2,  1'b0, 24'h27b212);
    px("code3",  1'b1, 6'd3,  1'b0, 24'hd80222);
    px("code10", 1'b1, 6'd10, 1'b0, 24'h000066);
    px("code12", 1'b1, 6'd12, 1'b0, 24'hb2b2b0);
    px("code63", 1'b1, 6'd63, 1'b0, 24'hb2b2b0);
    px("blank3", 1'b1, 6'd3,  1'b1, 24'h000000);
    px("idle0",  1'b0, 6'd0,  1'b0, 24'h000000);

    // Write/read collision on entry 2
    px("w_old", 1'b1, 6'd2, 1'b0, 24'h27b212);
    wr_en = 1'b1; wr_addr = 6'd2; wr_rgb = 24'h123456; wr_blink = 1'b0;
    px("w_new", 1'b1, 6'd2, 1'b0, 24'h123456);
    check("wr_err before bad write", 32'(wr_err), 32'd0);
    wr_en = 1'b1; wr_addr = 6'd20; wr_rgb = 24'hffffff; wr_blink = 1'b0;
    px("code20 after bad write", 1'b1, 6'd20, 1'b0, 24'hb2b2b0);
    px("idle1", 1'b0, 6'd0, 1'b0, 24'h000000);
    check("wr_err after bad write", 32'(wr_err), 32'd1);
    px("code2 kept", 1'b1, 6'd2, 1'b0, 24'h123456);

    // Blink on entry 5 with two frames per half-period
    wr_en = 1'b1; wr_addr = 6'd5; wr_rgb = 24'hf1ff0a; wr_blink = 1'b1;
    px("w5",      1'b0, 6'd0, 1'b0, 24'h000000);
    px("blink_a", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);
    frame_start = 1'b1;
    px("blink_b", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);
    px("blink_c", 1'b1, 6'd5, 1'b0, 24'h000000);
    frame_start = 1'b1;
    px("blink_d", 1'b1, 6'd5, 1'b0, 24'h000000);
    frame_start = 1'b1;
    px("plain_e", 1'b1, 6'd0, 1'b0, 24'hffffff);
    px("blink_f", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);
    frame_start = 1'b1;
    px("blink_g", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);
    px("blink_h", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);
    check("wr_err sticky", 32'(wr_err), 32'd1);

    // Reset mid-stream: flush, palette reload, write ignored during reset
    px("pre_rst", 1'b1, 6'd2, 1'b0, 24'h123456);
    pend_v = 1'b0;
    Reset = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd2; wr_rgb = 24'habcdef; wr_blink = 1'b0;
    px("in_rst", 1'b1, 6'd2, 1'b0, 24'h000000);
    Reset = 1'b0;
    pend_v = 1'b0;
    check("wr_err cleared by reset", 32'(wr_err), 32'd0);
    px("code2 reloaded", 1'b1, 6'd2, 1'b0, 24'h27b212);
    px("code5 unblinked", 1'b1, 6'd5, 1'b0, 24'hf1ff0a);

`ifdef PALETTE_FADE_EN
    fade_level = 4'd7;
    px("fade7", 1'b1, 6'd0, 1'b0, 24'h7f7f7f);
    fade_level = 4'd15;
    px("fade15", 1'b1, 6'd0, 1'b0, 24'hffffff);
`endif

    px("idle2", 1'b0, 6'd0, 1'b0, 24'h000000);
    px("idle3", 1'b0, 6'd0, 1'b0, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/palette_mapper.md
Name: palette_mapper

Overview:
- Registered, programmable successor to the fixed combinational colour-code decoder. Maps per-pixel colour codes from the sprite/background compositor to VGA RGB.
- Palette is a writable register file, reset-loaded with the game's standard 11 colours; unused entries reset to grey.
- Adds a 2-stage pipeline, a blanking override, and a per-entry blink attribute driven by a frame counter.
- Sits between the compositor and the VGA output pins.

Parameters:
- CODE_W, 6, colour-code width.
- NUM_COLORS, 16, palette depth; must be ≤ 2**CODE_W.
- CH_W, 8, bits per RGB channel.
- BLINK_FRAMES, 30, frames per blink half-period; must be ≥ 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  colorcode/blank qualify a pixel this cycle.
- colorcode  in  CODE_W  palette index.
- blank  in  1  forces black output for this pixel.
- frame_start  in  1  one-cycle pulse per frame.
- wr_en  in  1  palette write strobe.
- wr_addr  in  CODE_W  entry to write.
- wr_rgb  in  3*CH_W  {R,G,B} data.
- wr_blink  in  1  blink attribute for the entry.
- VGA_R, VGA_G, VGA_B  out  CH_W each  colour outputs.
- out_valid  out  1  outputs carry a pixel.
- wr_err  out  1  sticky flag: a write targeted an entry ≥ NUM_COLORS.

Behaviour:
- Reset contents:
  - Entries 0..10 = ffffff, 000000, 27b212, d80222, 5db1f0, f1ff0a, b2b2b0, f27a00, 663300, 8600b3, 000066.
  - Entries 11..NUM_COLORS-1 = b2b2b0.
  - All blink bits 0.
- Reset outputs: VGA_R/G/B = 0, out_valid = 0, wr_err = 0, frame counter = 0, blink phase = on.
- Stage 1: at each edge, registers pix_valid, colorcode and blank unconditionally.
- Stage 2: at each edge, registers RGB and out_valid from stage 1 and the palette.
- Latency: exactly 2 cycles, full throughput, no back-pressure.
- Code ≥ NUM_COLORS: returns b2b2b0 (default grey).
- blank = 1: returns 000000, regardless of code or blink.
- Blink: an entry with blink = 1 returns 000000 while blink phase is off.
- Blink counter:
  - Increments on each frame_start.
  - When it reaches BLINK_FRAMES-1 and frame_start is high, it wraps to 0 and the phase toggles.
  - The new phase applies to pixels registered into stage 2 on or after that edge.
- Stage-2 registers with out_valid = 0 still update; consumers ignore them.
- Palette write:
  - Occurs on the edge where wr_en = 1 and wr_addr < NUM_COLORS; updates RGB and the blink bit.
  - If wr_addr ≥ NUM_COLORS, the write is ignored and wr_err sets; it clears only on Reset.
- Write/read collision: a write at edge W is visible to pixels captured into stage 1 at edge ≥ W.
  - A pixel captured at W-1 sees the old value; there is no bypass.
- Reset asserted mid-stream:
  - Pipeline is flushed: out_valid = 0 on the next edge.
  - Palette is reloaded to defaults and user writes are lost.
  - wr_en is ignored while Reset = 1.
- Simultaneous wr_en and frame_start: both take effect independently.

Optional Feature:
- Macro: PALETTE_FADE_EN.
- When defined:
  - Adds input fade_level [3:0].
  - Stage 2 outputs channel = (c * (fade_level + 1)) >> 4, truncated to CH_W bits.
  - fade_level = 15 gives the unmodified colour; 0 gives c/16.
  - fade_level is sampled in stage 1 along with the pixel; latency is unchanged.
- When undefined: no fade_level port and no multiplier logic; outputs are the raw palette value.

Decomposition:
- Package palette_pkg holds:
  - rgb_t struct {R,G,B} of CH_W = 8 bits.
  - The default colour constants and the COLOR_DEFAULT grey.
  - The reset palette as a constant array function of NUM_COLORS.
- One sub-module, blink_timer: frame counter and phase toggle, with ports Clk, Reset, frame_start, phase.

Test Plan:
- Reset, then codes 0,2,3,10 on consecutive cycles with pix_valid = 1 → two cycles later, out_valid = 1 and RGB = ffffff, 27b212, d80222, 000066.
- Code 12 and code 63 → b2b2b0; blank = 1 with code 3 → 000000.
- Write entry 2 = 123456 at edge W:
  - Pixel code 2 captured at W-1 → 27b212.
  - Pixel code 2 captured at W → 123456.
  - Write with wr_addr = 20 → ignored and wr_err = 1.
- BLINK_FRAMES = 2: set the blink bit on entry 5 and hold code 5 → f1ff0a for 2 frame_start pulses, then 000000 for 2, then f1ff0a again.
- Assert Reset one cycle while streaming after writing entry 2 → out_valid drops the next cycle; entry 2 returns 27b212 after reset.
- With PALETTE_FADE_EN defined, fade_level = 7 on code 0 → 7f7f7f; fade_level = 15 → ffffff.
